// File: rtl/onehot_decoder_4to16.sv
// Registered binary-to-one-hot decoder: enc selects one of M = 2**N dec lines, one clock of latency.
// Optional output blanking input en is compiled in when DECODER_BLANK_EN is defined.
module onehot_decoder_4to16 #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] enc,
`ifdef DECODER_BLANK_EN
    input  logic         en,
`endif
    output logic [M-1:0] dec
);

    // Reject illegal configurations at elaboration so a mis-sized select bus never builds.
    generate
        if ((N < 1) || (N > 8)) begin : g_bad_n
            $error("onehot_decoder_4to16: N must be in 1..8");
        end
        if (M != (1 << N)) begin : g_bad_m
            $error("onehot_decoder_4to16: M must equal 2**N");
        end
    endgenerate

    logic [M-1:0] onehot_s;
    logic [M-1:0] dec_next_s;
    logic [M-1:0] dec_r;
    logic         blank_s;

`ifdef DECODER_BLANK_EN
    assign blank_s = en;
`else
    assign blank_s = 1'b0;
`endif

    // One-hot decode; an unknown enc falls to the else branch, so every bit reads zero.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < M; i++) begin
            if (enc == N'(i)) begin
                onehot_s[i] = 1'b1;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // Select between the decode and a blanked (all-zero) output.
    always_comb begin
        dec_next_s = '0;
        if (blank_s == 1'b1) begin
            dec_next_s = '0;
        end else begin
            dec_next_s = onehot_s;
        end
    end

    // Output register, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_r <= '0;
        end else begin
            dec_r <= dec_next_s;
        end
    end

    assign dec = dec_r;

endmodule

// File: tb/tb_onehot_decoder_4to16.sv
// Self-checking bench for onehot_decoder_4to16: vector table, corner sequences, random run
// against a reference model, plus a 3-to-8 instance.
module tb_onehot_decoder_4to16;

    typedef struct {
        logic [3:0]  enc;
        logic [15:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  enc;
    logic [15:0] dec;
    logic [2:0]  enc3;
    logic [7:0]  dec3;
`ifdef DECODER_BLANK_EN
    logic        en;
    logic        en3;
`endif

    int vectors;
    int miscompares;

    onehot_decoder_4to16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enc   (enc),
`ifdef DECODER_BLANK_EN
        .en    (en),
`endif
        .dec   (dec)
    );

    onehot_decoder_4to16 #(.N(3), .M(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .enc   (enc3),
`ifdef DECODER_BLANK_EN
        .en    (en3),
`endif
        .dec   (dec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a one-hot word with only bit k set, built by indexing a zeroed word.
    function automatic logic [15:0] ref_onehot(input int k);
        logic [15:0] w;
        w = 16'h0000;
        w[k] = 1'b1;
        return w;
    endfunction

    vec_t tbl[16];

    initial begin
        vectors     = 0;
        miscompares = 0;
        tbl = '{
            '{4'd0,  16'h0001}, '{4'd1,  16'h0002}, '{4'd2,  16'h0004}, '{4'd3,  16'h0008},
            '{4'd4,  16'h0010}, '{4'd5,  16'h0020}, '{4'd6,  16'h0040}, '{4'd7,  16'h0080},
            '{4'd8,  16'h0100}, '{4'd9,  16'h0200}, '{4'd10, 16'h0400}, '{4'd11, 16'h0800},
            '{4'd12, 16'h1000}, '{4'd13, 16'h2000}, '{4'd14, 16'h4000}, '{4'd15, 16'h8000}
        };

        rst_n = 1'b0;
        enc   = 4'h7;
        enc3  = 3'd0;
`ifdef DECODER_BLANK_EN
        en    = 1'b0;
        en3   = 1'b0;
`endif

        // Reset held with clock running
        #2;
        chk("reset_initial", dec, 16'h0000);
        tick();
        chk("reset_hold1", dec, 16'h0000);
        tick();
        chk("reset_hold2", dec, 16'h0000);
        chk("reset_hold_n3", {8'h00, dec3}, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("reset_release", dec, 16'h0080);

        // Sweep table
        for (int i = 0; i < 16; i++) begin
            enc = tbl[i].enc;
            tick();
            chk($sformatf("sweep_enc%0d", i), dec, tbl[i].exp);
            chk($sformatf("sweep_pop%0d", i), 16'($countones(dec)), 16'd1);
        end

        // Hold: constant enc keeps dec constant
        enc = 4'd9;
        tick();
        tick();
        chk("hold_9", dec, 16'h0200);

        // Latency: change enc mid-cycle, dec only moves on the next edge
        enc = 4'd3;
        tick();
        chk("lat_before", dec, 16'h0008);
        #2;
        enc = 4'd12;
        #1;
        chk("lat_midcycle", dec, 16'h0008);
        tick();
        chk("lat_after", dec, 16'h1000);

        // Async reset between edges
        enc = 4'd5;
        tick();
        chk("async_pre", dec, 16'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear", dec, 16'h0000);
        tick();
        chk("async_held", dec, 16'h0000);
        #2;
        rst_n = 1'b1;
        enc = 4'd14;
        tick();
        chk("async_resume", dec, 16'h4000);

`ifdef DECODER_BLANK_EN
        // Blanking sweep then release
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enc = 4'(i);
            tick();
            chk($sformatf("blank_enc%0d", i), dec, 16'h0000);
        end
        en  = 1'b0;
        enc = 4'd10;
        tick();
        chk("unblank_10", dec, 16'h0400);
`endif

        // 3-to-8 instance sweep
        for (int i = 0; i < 8; i++) begin
            enc3 = 3'(i);
            tick();
            chk($sformatf("n3_enc%0d", i), {8'h00, dec3}, ref_onehot(i));
        end

        // Random stimulus against the reference model
        for (int n = 0; n < 300; n++) begin
            int          v;
            logic        blank;
            logic [15:0] exp;
            v     = int'($urandom_range(0, 15));
            blank = 1'b0;
`ifdef DECODER_BLANK_EN
            blank = ($urandom_range(0, 3) == 0);
            en    = blank;
`endif
            enc = 4'(v);
            if (($urandom_range(0, 1) == 1)) begin
                #2;
            end
            tick();
            exp = blank ? 16'h0000 : ref_onehot(v);
            chk($sformatf("rand%0d", n), dec, exp);
            if (!blank) begin
                chk($sformatf("rand_pop%0d", n), 16'($countones(dec)), 16'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
